// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the core and the RV32M unit.
//   master (core side): drives start, funct3, rs1_val, rs2_val, rd_addr;
//                       observes busy, done, wr_en, wr_addr, wr_data.
//   slave (unit side) : the mirror image.
interface muldiv_if #(
  parameter int D_WIDTH       = 32,
  parameter int ADDRESS_WIDTH = 5
) ();
  logic                     start;
  logic [2:0]               funct3;
  logic [D_WIDTH-1:0]       rs1_val;
  logic [D_WIDTH-1:0]       rs2_val;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic                     busy;
  logic                     done;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [D_WIDTH-1:0]       wr_data;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_addr,
    input  busy, done, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_addr,
    output busy, done, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_if.slave -- start/funct3/rs1_val/rs2_val/rd_addr in,
//           busy/done/wr_en/wr_addr/wr_data out (register-file write port).
// Fixed latency: start in cycle 0, PREP cycle 1, CALC cycles 2..D_WIDTH+1,
// FIX cycle D_WIDTH+2, DONE (one-cycle write pulse) cycle D_WIDTH+3.
module muldiv_unit #(
  parameter int D_WIDTH       = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  muldiv_if.slave   bus
);

  localparam logic [5:0]             CNT_LAST = 6'(D_WIDTH - 1);
  localparam logic [D_WIDTH-1:0]     ZERO_W   = {D_WIDTH{1'b0}};
  localparam logic [D_WIDTH-1:0]     ONES_W   = {D_WIDTH{1'b1}};
  localparam logic [D_WIDTH-1:0]     ONE_W    = {{(D_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [D_WIDTH-1:0]     MIN_W    = {1'b1, {(D_WIDTH-1){1'b0}}};
  localparam logic [2*D_WIDTH-1:0]   ZERO_2W  = {(2*D_WIDTH){1'b0}};
  localparam logic [2*D_WIDTH-1:0]   ONE_2W   = {{(2*D_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_A = {ADDRESS_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                   state;
  logic [2:0]               op;
  logic [D_WIDTH-1:0]       opa;      // multiplicand / dividend (shifted in CALC for divide)
  logic [D_WIDTH-1:0]       opb;      // multiplier (shifted in CALC for multiply) / divisor
  logic [D_WIDTH-1:0]       rs1_raw;  // original rs1, returned by REM/REMU on divide-by-zero
  logic [ADDRESS_WIDTH-1:0] rd;
  logic                     neg;
  logic                     div0;
  logic                     ovf;
  logic [5:0]               cnt;
  logic [2*D_WIDTH-1:0]     acc;      // product, or {remainder, quotient}
  logic                     busy;
  logic                     done;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [D_WIDTH-1:0]       wr_data;

  // Combinational helpers
  logic                     sign1, sign2, signed1, signed2;
  logic                     prep_neg;
  logic [D_WIDTH-1:0]       prep_a, prep_b;
  logic [2*D_WIDTH-1:0]     mul_next;
  logic [D_WIDTH:0]         rem_shift, diff;
  logic [2*D_WIDTH-1:0]     div_next;
  logic [2*D_WIDTH-1:0]     prod_fix;
  logic [D_WIDTH-1:0]       quot_fix, rem_fix;
  logic [D_WIDTH-1:0]       result;

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;

  // Operand conditioning used in PREP: signedness, magnitudes, result sign.
  always_comb begin
    sign1    = opa[D_WIDTH-1];
    sign2    = opb[D_WIDTH-1];
    signed1  = 1'b0;
    signed2  = 1'b0;
    prep_neg = 1'b0;
    case (op)
      3'b001: begin signed1 = 1'b1; signed2 = 1'b1; prep_neg = sign1 ^ sign2; end // MULH
      3'b010: begin signed1 = 1'b1; signed2 = 1'b0; prep_neg = sign1;         end // MULHSU
      3'b100: begin signed1 = 1'b1; signed2 = 1'b1; prep_neg = sign1 ^ sign2; end // DIV
      3'b110: begin signed1 = 1'b1; signed2 = 1'b1; prep_neg = sign1;         end // REM: dividend sign
      default: begin signed1 = 1'b0; signed2 = 1'b0; prep_neg = 1'b0;         end
    endcase
    if (signed1 && sign1) begin
      prep_a = ~opa + ONE_W;
    end else begin
      prep_a = opa;
    end
    if (signed2 && sign2) begin
      prep_b = ~opb + ONE_W;
    end else begin
      prep_b = opb;
    end
  end

  // One CALC iteration for each algorithm.
  // Multiply walks the multiplier MSB-first: acc = 2*acc + (bit ? a : 0).
  // Divide shifts the next dividend bit into the partial remainder and
  // keeps the difference only if it did not go negative (restoring).
  always_comb begin
    mul_next  = {acc[2*D_WIDTH-2:0], 1'b0} +
                (opb[D_WIDTH-1] ? {ZERO_W, opa} : ZERO_2W);
    rem_shift = {acc[2*D_WIDTH-1:D_WIDTH], opa[D_WIDTH-1]};
    diff      = rem_shift - {1'b0, opb};
    if (!diff[D_WIDTH]) begin
      div_next = {diff[D_WIDTH-1:0], acc[D_WIDTH-2:0], 1'b1};
    end else begin
      div_next = {rem_shift[D_WIDTH-1:0], acc[D_WIDTH-2:0], 1'b0};
    end
  end

  // FIX: sign correction, special cases and result selection.
  always_comb begin
    if (neg) begin
      prod_fix = ~acc + ONE_2W;
      quot_fix = ~acc[D_WIDTH-1:0] + ONE_W;
      rem_fix  = ~acc[2*D_WIDTH-1:D_WIDTH] + ONE_W;
    end else begin
      prod_fix = acc;
      quot_fix = acc[D_WIDTH-1:0];
      rem_fix  = acc[2*D_WIDTH-1:D_WIDTH];
    end
    case (op)
      3'b000: result = prod_fix[D_WIDTH-1:0];
      3'b001, 3'b010, 3'b011: result = prod_fix[2*D_WIDTH-1:D_WIDTH];
      3'b100, 3'b101: begin
        if (div0) begin
          result = ONES_W;
        end else if (ovf && (op == 3'b100)) begin
          result = MIN_W;
        end else begin
          result = quot_fix;
        end
      end
      3'b110, 3'b111: begin
        if (div0) begin
          result = rs1_raw;
        end else if (ovf && (op == 3'b110)) begin
          result = ZERO_W;
        end else begin
          result = rem_fix;
        end
      end
      default: result = ZERO_W;
    endcase
  end

  // Control FSM plus datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op      <= 3'b000;
      opa     <= ZERO_W;
      opb     <= ZERO_W;
      rs1_raw <= ZERO_W;
      rd      <= ZERO_A;
      neg     <= 1'b0;
      div0    <= 1'b0;
      ovf     <= 1'b0;
      cnt     <= 6'd0;
      acc     <= ZERO_2W;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= ZERO_A;
      wr_data <= ZERO_W;
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          wr_en <= 1'b0;
          if (bus.start) begin
            op      <= bus.funct3;
            opa     <= bus.rs1_val;
            opb     <= bus.rs2_val;
            rs1_raw <= bus.rs1_val;
            rd      <= bus.rd_addr;
            busy    <= 1'b1;
            state   <= PREP;
          end else begin
            busy    <= 1'b0;
          end
        end
        PREP: begin
          // Special cases are detected on the raw operands, before abs().
          div0  <= (opb == ZERO_W);
          ovf   <= (opa == MIN_W) && (opb == ONES_W);
          neg   <= prep_neg;
          opa   <= prep_a;
          opb   <= prep_b;
          cnt   <= 6'd0;
          acc   <= ZERO_2W;
          state <= CALC;
        end
        CALC: begin
          if (op[2]) begin
            acc <= div_next;
            opa <= {opa[D_WIDTH-2:0], 1'b0};
          end else begin
            acc <= mul_next;
            opb <= {opb[D_WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 6'd1;
          if (cnt == CNT_LAST) begin
            state <= FIX;
          end else begin
            state <= CALC;
          end
        end
        FIX: begin
          wr_data <= result;
          wr_addr <= rd;
          done    <= 1'b1;
          wr_en   <= (rd != ZERO_A);  // x0 is never written
          state   <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          wr_en <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          wr_en <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (table vectors,
// multi-cycle corner sequences, randomized ops against an arithmetic model).
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  muldiv_if #(.D_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();

  muldiv_unit #(.D_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model straight from the RV32M definitions using 64-bit math.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] up;
    int          ia, ib;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    up = {32'h0, a} * {32'h0, b};
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: r = up[63:32];
      3'd4: begin
        if (b == 32'h0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = ia / ib;
      end
      3'd5: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = ia % ib;
      end
      default: r = (b == 32'h0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Issue one op at a falling edge (cycle 0) and check the full timeline.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input bit inject);
    int          done_cyc;
    int          busy_err;
    logic        got_en;
    logic [4:0]  got_addr;
    logic [31:0] got_data;
    done_cyc = 0;
    busy_err = 0;
    got_en   = 1'b0;
    got_addr = 5'd0;
    got_data = 32'h0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.funct3  = f3;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_addr = rd;
    chk({name, "_busy_c0"}, {31'h0, bus.busy}, 32'h0);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.start   = 1'b0;
        bus.rs1_val = $urandom;
        bus.rs2_val = $urandom;
        bus.funct3  = 3'($urandom_range(0, 7));
        bus.rd_addr = 5'($urandom_range(0, 31));
      end
      if (inject && cyc == 10) begin
        bus.start   = 1'b1;
        bus.funct3  = 3'b101;
        bus.rs1_val = 32'd5;
        bus.rs2_val = 32'd0;
        bus.rd_addr = 5'd9;
      end
      if (inject && cyc == 11) bus.start = 1'b0;
      if (bus.busy !== 1'b1) busy_err++;
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        got_en   = bus.wr_en;
        got_addr = bus.wr_addr;
        got_data = bus.wr_data;
        break;
      end
    end
    chk({name, "_done_cycle"}, 32'(done_cyc), 32'd35);
    chk({name, "_busy_window"}, 32'(busy_err), 32'd0);
    chk({name, "_wr_en"}, {31'h0, got_en}, {31'h0, (rd != 5'd0)});
    chk({name, "_wr_addr"}, {27'h0, got_addr}, {27'h0, rd});
    chk({name, "_wr_data"}, got_data, exp);
    @(negedge clk);
    chk({name, "_post_busy"}, {31'h0, bus.busy}, 32'h0);
    chk({name, "_post_pulse"}, {30'h0, bus.done, bus.wr_en}, 32'h0);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;
    int          stray;

    total = 0;
    bad   = 0;

    vecs[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF};
    vecs[6]  = '{3'b101, 32'd100,       32'd7,         5'd7,  32'd14};
    vecs[7]  = '{3'b111, 32'd100,       32'd7,         5'd8,  32'd2};
    vecs[8]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000};
    vecs[9]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0};
    vecs[10] = '{3'b101, 32'd5,         32'd0,         5'd12, 32'hFFFF_FFFF};
    vecs[11] = '{3'b111, 32'd5,         32'd0,         5'd13, 32'd5};
    vecs[12] = '{3'b100, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF};
    vecs[13] = '{3'b110, 32'hFFFF_FFF9, 32'd0,         5'd15, 32'hFFFF_FFF9};
    vecs[14] = '{3'b000, 32'd3,         32'd4,         5'd0,  32'd12};
    vecs[15] = '{3'b001, 32'd7,         32'hFFFF_FFFD, 5'd31, 32'hFFFF_FFFF};

    bus.start   = 1'b0;
    bus.funct3  = 3'b000;
    bus.rs1_val = 32'h0;
    bus.rs2_val = 32'h0;
    bus.rd_addr = 5'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_busy",  {31'h0, bus.busy},  32'h0);
    chk("reset_done",  {31'h0, bus.done},  32'h0);
    chk("reset_wr_en", {31'h0, bus.wr_en}, 32'h0);
    chk("reset_addr",  {27'h0, bus.wr_addr}, 32'h0);
    chk("reset_data",  bus.wr_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp, 1'b0);
    end

    // Second start during CALC must be ignored.
    run_op("ignored_start", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1);

    // Reset in cycle 20 aborts the operation with no write.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.funct3  = 3'b101;
    bus.rs1_val = 32'd1000;
    bus.rs2_val = 32'd3;
    bus.rd_addr = 5'd17;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",  {31'h0, bus.busy},  32'h0);
    chk("abort_pulse", {30'h0, bus.done, bus.wr_en}, 32'h0);
    chk("abort_addr",  {27'h0, bus.wr_addr}, 32'h0);
    chk("abort_data",  bus.wr_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0) stray++;
    end
    chk("abort_no_write", 32'(stray), 32'h0);
    run_op("after_reset", 3'b101, 32'd1000, 32'd3, 5'd17, 32'd333, 1'b0);

    // Randomized ops against the arithmetic model.
    for (int k = 0; k < 40; k++) begin
      rf3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h0;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'hFFFF_FFFF;
        1: rb = 32'h0;
        2: rb = 32'($urandom_range(1, 16));
        default: rb = $urandom;
      endcase
      rrd = 5'($urandom_range(0, 31));
      run_op($sformatf("rnd%0d_f%0d", k, rf3), rf3, ra, rb, rrd, ref_model(rf3, ra, rb), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
